// File: rtl/if_id_queue_pkg.sv
// Shared constants and entry layout for the IF/ID decoupling queue.
// The MIPS_NOP, IF_ID_QUEUE_DEPTH and IF_ID_ENTRY_W macros are also provided
// here for code that expects the MIPS header names.
`ifndef MIPS_NOP
`define MIPS_NOP 32'h0000_0000
`endif
`ifndef IF_ID_QUEUE_DEPTH
`define IF_ID_QUEUE_DEPTH 2
`endif
`ifndef IF_ID_ENTRY_W
`define IF_ID_ENTRY_W 64
`endif

package if_id_queue_pkg;

  localparam logic [31:0] MIPS_NOP          = 32'h0000_0000;
  localparam int unsigned IF_ID_QUEUE_DEPTH = 2;
  localparam int unsigned IF_ID_ENTRY_W     = 64;

  // One queued fetch result: PC+4 and the instruction word.
  typedef struct packed {
    logic [31:0] next_pc;
    logic [31:0] instr;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_queue_ram.sv
// DEPTH x 64 entry storage: synchronous write, asynchronous read, no reset.
module if_id_queue_ram
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IF_ID_QUEUE_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [PTR_W-1:0]   waddr_i,
  input  if_id_entry_t       wdata_i,
  input  logic [PTR_W-1:0]   raddr_i,
  output if_id_entry_t       rdata_o
);

  if_id_entry_t mem_q [DEPTH];

  // Write port; contents deliberately survive reset and flush.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue with valid/ready on both sides and flush on taken
// branch. Optional feature: define IF_ID_QUEUE_BYPASS_EN to let a push into an
// empty queue fall through combinationally to the decode side.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = IF_ID_QUEUE_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_flush,
  input  logic             i_halt,
  input  logic             i_push_valid,
  output logic             o_push_ready,
  input  logic [31:0]      i_next_pc,
  input  logic [31:0]      i_instr,
  output logic             o_valid,
  input  logic             i_pop_ready,
  output logic [31:0]      o_next_pc,
  output logic [31:0]      o_instr,
  output logic [PTR_W:0]   o_count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  if_id_entry_t wr_entry;
  if_id_entry_t rd_entry;
  logic         empty;
  logic         valid_c;
  logic         push;
  logic         pop;
  logic         mem_we;

  assign wr_entry = '{next_pc: i_next_pc, instr: i_instr};
  assign empty    = (count_q == '0);

  if_id_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  // Head presentation: masked to NOP when empty, optional fall-through.
  always_comb begin
    valid_c   = !empty;
    o_instr   = empty ? MIPS_NOP : rd_entry.instr;
    o_next_pc = empty ? 32'h0 : rd_entry.next_pc;
`ifdef IF_ID_QUEUE_BYPASS_EN
    if (empty && i_push_valid) begin
      valid_c   = 1'b1;
      o_instr   = i_instr;
      o_next_pc = i_next_pc;
    end
`endif
  end

  assign o_valid      = valid_c;
  assign o_count      = count_q;
  assign o_push_ready = (count_q != CNT_W'(DEPTH)) && !i_halt;

  // Handshake decode and next pointer/count; flush dominates everything.
  always_comb begin
    push     = i_push_valid && o_push_ready && !i_flush;
    pop      = valid_c && i_pop_ready && !i_halt && !i_flush;
    mem_we   = push;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (empty && push && pop) begin
      // Fall-through entry consumed directly; never stored.
      mem_we = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: queue-based reference model checked every cycle plus
// hand-computed expectations along the directed scenarios.
module tb_if_id_queue;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset;
  logic             i_flush = 1'b0;
  logic             i_halt = 1'b0;
  logic             i_push_valid = 1'b0;
  logic             o_push_ready;
  logic [31:0]      i_next_pc = '0;
  logic [31:0]      i_instr = '0;
  logic             o_valid;
  logic             i_pop_ready = 1'b0;
  logic [31:0]      o_next_pc;
  logic [31:0]      o_instr;
  logic [PTR_W:0]   o_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [63:0] mq [$];

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_flush      (i_flush),
    .i_halt       (i_halt),
    .i_push_valid (i_push_valid),
    .o_push_ready (o_push_ready),
    .i_next_pc    (i_next_pc),
    .i_instr      (i_instr),
    .o_valid      (o_valid),
    .i_pop_ready  (i_pop_ready),
    .o_next_pc    (o_next_pc),
    .o_instr      (o_instr),
    .o_count      (o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Expected head as seen by decode given the model contents and live inputs.
  task automatic model_head(output bit v, output logic [31:0] pc, output logic [31:0] ins);
    v = 1'b0; pc = 32'h0; ins = 32'h0;
    if (mq.size() > 0) begin
      v = 1'b1; pc = mq[0][63:32]; ins = mq[0][31:0];
    end
`ifdef IF_ID_QUEUE_BYPASS_EN
    else if (i_push_valid) begin
      v = 1'b1; pc = i_next_pc; ins = i_instr;
    end
`endif
  endtask

  // Reference model: occupancy is simply the length of an ordered list.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
    end else if (i_flush) begin
      mq.delete();
    end else begin : upd
      bit ev, psh, pp;
      logic [31:0] hp, hi;
      model_head(ev, hp, hi);
      psh = i_push_valid && (mq.size() < DEPTH) && !i_halt;
      pp  = ev && i_pop_ready && !i_halt;
      if (pp && mq.size() == 0) psh = 1'b0;
      else if (pp) void'(mq.pop_front());
      if (psh) mq.push_back({i_next_pc, i_instr});
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin : cmp
      bit ev;
      logic [31:0] ep, ei;
      model_head(ev, ep, ei);
      chk("m_valid", 32'(o_valid), 32'(ev));
      chk("m_instr", o_instr, ei);
      chk("m_next_pc", o_next_pc, ep);
      chk("m_count", 32'(o_count), 32'(mq.size()));
      chk("m_push_ready", 32'(o_push_ready), 32'((mq.size() != DEPTH) && !i_halt));
    end
  end

  // Apply one cycle of inputs; returns just after the following rising edge.
  task automatic drive(input bit pv, input logic [31:0] pc, input logic [31:0] ins,
                       input bit pr, input bit fl, input bit hl);
    i_push_valid = pv; i_next_pc = pc; i_instr = ins;
    i_pop_ready = pr; i_flush = fl; i_halt = hl;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #1 reset = 1'b1;
    idle();
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_push_ready", 32'(o_push_ready), 32'd1);

    // Fill and stall.
    drive(1'b1, 32'd4, 32'h20010005, 1'b0, 1'b0, 1'b0);
    chk("fill1_count", 32'(o_count), 32'd1);
    chk("fill1_instr", o_instr, 32'h20010005);
    drive(1'b1, 32'd8, 32'h20020007, 1'b0, 1'b0, 1'b0);
    chk("fill_count", 32'(o_count), 32'd2);
    chk("fill_push_ready", 32'(o_push_ready), 32'd0);
    chk("fill_head_instr", o_instr, 32'h20010005);
    chk("fill_head_pc", o_next_pc, 32'd4);
    drive(1'b1, 32'd12, 32'h20030009, 1'b0, 1'b0, 1'b0);
    chk("refuse_count", 32'(o_count), 32'd2);
    chk("refuse_head", o_instr, 32'h20010005);

    // Full with pop: push still refused.
    drive(1'b1, 32'd12, 32'h20030009, 1'b1, 1'b0, 1'b0);
    chk("drain1_instr", o_instr, 32'h20020007);
    chk("drain1_pc", o_next_pc, 32'd8);
    chk("drain1_count", 32'(o_count), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("drain2_valid", 32'(o_valid), 32'd0);
    chk("drain2_count", 32'(o_count), 32'd0);
    chk("drain2_instr", o_instr, 32'h0);

    // Simultaneous push/pop at count 1 across pointer wrap.
    drive(1'b1, 32'h100, 32'h20110001, 1'b0, 1'b0, 1'b0);
    chk("wrap_head0", o_instr, 32'h20110001);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h104 + 32'(4 * i), 32'h20120000 + 32'(i), 1'b1, 1'b0, 1'b0);
      chk("wrap_count", 32'(o_count), 32'd1);
      chk("wrap_instr", o_instr, 32'h20120000 + 32'(i));
      chk("wrap_pc", o_next_pc, 32'h104 + 32'(4 * i));
    end

    // Flush beats push and halt.
    drive(1'b1, 32'h180, 32'h20130003, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_count", 32'(o_count), 32'd2);
    drive(1'b1, 32'h200, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1);
    chk("flush_count", 32'(o_count), 32'd0);
    chk("flush_valid", 32'(o_valid), 32'd0);
    chk("flush_instr", o_instr, 32'h0);
    chk("flush_pc", o_next_pc, 32'h0);
    idle();
    chk("post_flush_valid", 32'(o_valid), 32'd0);
    drive(1'b1, 32'h2F0, 32'h20140001, 1'b0, 1'b0, 1'b0);
    chk("post_flush_push", o_instr, 32'h20140001);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Halt freeze.
    drive(1'b1, 32'h300, 32'h2004000B, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h304, 32'h2005000D, 1'b1, 1'b0, 1'b1);
      chk("halt_count", 32'(o_count), 32'd1);
      chk("halt_head", o_instr, 32'h2004000B);
      chk("halt_push_ready", 32'(o_push_ready), 32'd0);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("unhalt_drain", 32'(o_count), 32'd0);

    // Asynchronous reset mid-stream drops entries.
    drive(1'b1, 32'h400, 32'h20150001, 1'b0, 1'b0, 1'b0);
    i_push_valid = 1'b0;
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("async_rst_count", 32'(o_count), 32'd0);
    chk("async_rst_valid", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b1, 32'h500, 32'h20160001, 1'b0, 1'b0, 1'b0);
    chk("after_rst_push", o_instr, 32'h20160001);
    chk("after_rst_count", 32'(o_count), 32'd1);
    idle();
    idle();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
